cache_control_4: RTL and testbench
==================================

Name: cache_control_4

Overview:
- Sequencing FSM for the 4-way, 8-set, 256-bit-line cache datapath.
- Accepts CPU line-granular read/write requests and drives all datapath strobes, selects and loads.
- Runs hit, writeback and allocate sequences against physical memory.
- Maintains 3-bit tree pseudo-LRU per set.

Parameters:
- s_way, 4, number of ways; fixed, only 4 supported.
- s_lru, 3, PLRU width per set.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  memory line read, held until pmem_resp
- pmem_write  out  1  memory line write, held until pmem_resp
- pmem_resp  in  1  memory completion pulse
- hit  in  4  per-way hit from datapath
- dirty_out  in  4  per-way dirty bit of indexed set
- lru_out  in  3  PLRU bits of indexed set
- read_en  out  1  common read strobe to tag/valid/dirty/data/LRU arrays
- tag_load, valid_load, dirty_load  out  4 each  per-way array loads
- valid_in, dirty_in  out  4 each  per-way array write data
- write_sel_way  out  8  2 bits per way: 00 none, 01 full line, 10 byte-enabled
- write_read_sel  out  4  per-way data source: 0 memory line, 1 CPU wdata
- lru_load  out  1  PLRU write
- lru_in  out  3  new PLRU bits
- way_sel  out  2  drives which_tag and cacheline_sel together
- new_address_sel  out  1  0 CPU address, 1 victim tag address

Behaviour:
- States: IDLE, CHECK, WB, ALLOC, REREAD. Reset enters IDLE.
- Reset values: all outputs 0.
- Reset mid-operation drops pmem_read/pmem_write the next cycle; the transaction is abandoned.
- read_en is 1 in IDLE, CHECK, WB and REREAD, and 0 in ALLOC. Array outputs are valid one cycle after read_en.
- IDLE: on mem_read or mem_write go to CHECK. If both are asserted, the request is a write.
- CHECK, hit in way h (one-hot):
  - way_sel=h; mem_resp=1; lru_load=1; go to IDLE.
  - Write hit additionally: write_sel_way[h]=10, write_read_sel[h]=1, dirty_load[h]=1, dirty_in[h]=1.
  - Hit latency is 2 cycles: request seen in IDLE, response in CHECK.
- CHECK, miss: victim v is derived from lru_out (see PLRU below); way_sel=v.
  - dirty_out[v]=1 -> WB.
  - Otherwise -> ALLOC.
- Multiple hit bits set is illegal; the lowest-index way wins.
- WB:
  - new_address_sel=1, way_sel=v, pmem_write=1.
  - On pmem_resp -> ALLOC.
- ALLOC:
  - new_address_sel=0, pmem_read=1.
  - On the pmem_resp cycle: write_sel_way[v]=01, write_read_sel[v]=0, tag_load[v]=1, valid_load[v]=1, valid_in[v]=1, dirty_load[v]=1, dirty_in[v]=0; then -> REREAD.
- REREAD: one cycle, read_en=1, -> CHECK. CHECK then hits.
- Victim v is latched on CHECK exit and held through WB/ALLOC.
- PLRU encoding:
  - b0 root: 0 selects ways 0/1, 1 selects ways 2/3.
  - b1 selects within 0/1; b2 selects within 2/3.
  - Victim = b0 ? (b2 ? 3 : 2) : (b1 ? 1 : 0).
- PLRU update on hit to way w (unlisted bits keep lru_out):
  - w0: b0=1, b1=1
  - w1: b0=1, b1=0
  - w2: b0=0, b2=1
  - w3: b0=0, b2=0
- pmem_resp outside WB/ALLOC is ignored.
- mem_resp never asserts outside CHECK.

Optional Feature:
- Macro: CACHE_PERF_CNT_EN.
- Enabled: adds outputs hit_count, miss_count and wb_count, 32 bits each, saturating at all-ones, cleared by rst.
  - hit_count increments on CHECK hits that do not follow REREAD.
  - miss_count increments on CHECK misses.
  - wb_count increments on WB exit.
- Disabled: the ports exist but are constant 0, and no counter registers are built.

Test Plan:
- Reset, then mem_read to an empty set -> ALLOC, pmem_read asserted until pmem_resp, REREAD, CHECK hit way 0, mem_resp exactly once; lru_in=3'b011.
- Four reads with distinct tags in one set, then a read to tag 0 -> hits way 0 in 2 cycles with no pmem activity.
- Write hit to way 2 with mem_byte_enable=32'h0000000F -> write_sel_way=8'b00100000, dirty_in[2]=1, mem_resp in the CHECK cycle.
- Fill set, dirty victim way 1 (lru_out=3'b010), then read miss -> WB with new_address_sel=1, way_sel=1, then ALLOC; pmem_write precedes pmem_read.
- Assert rst during ALLOC with pmem_read high -> pmem_read=0 the next cycle, state IDLE, mem_resp stays 0.
- With CACHE_PERF_CNT_EN: 1 miss with writeback, then 2 hits -> miss_count=1, wb_count=1, hit_count=2.

Source files
------------

// File: rtl/cache_control_4.sv
// Sequencing FSM for the 4-way, 8-set cache: hit, writeback, allocate, PLRU.
// Optional CACHE_PERF_CNT_EN builds saturating hit/miss/writeback counters.
module cache_control_4 #(
    parameter int s_way = 4,
    parameter int s_lru = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic [s_way-1:0]     hit,
    input  logic [s_way-1:0]     dirty_out,
    input  logic [s_lru-1:0]     lru_out,
    output logic                 read_en,
    output logic [s_way-1:0]     tag_load,
    output logic [s_way-1:0]     valid_load,
    output logic [s_way-1:0]     dirty_load,
    output logic [s_way-1:0]     valid_in,
    output logic [s_way-1:0]     dirty_in,
    output logic [2*s_way-1:0]   write_sel_way,
    output logic [s_way-1:0]     write_read_sel,
    output logic                 lru_load,
    output logic [s_lru-1:0]     lru_in,
    output logic [1:0]           way_sel,
    output logic                 new_address_sel,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
    output logic [31:0]          wb_count
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WB,
        ALLOC,
        REREAD
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] victim_q, victim_d;
    logic       write_q, write_d;

    logic       hit_any;
    logic [1:0] hit_way;
    logic [1:0] plru_victim;
    logic [2:0] plru_next;

    // Lowest-index way wins if the datapath ever reports several hits.
    always_comb begin
        hit_any = |hit;
        if (hit[0])      hit_way = 2'd0;
        else if (hit[1]) hit_way = 2'd1;
        else if (hit[2]) hit_way = 2'd2;
        else             hit_way = 2'd3;
    end

    assign plru_victim = lru_out[0] ? {1'b1, lru_out[2]}
                                    : {1'b0, lru_out[1]};

    always_comb begin
        case (hit_way)
            2'd0:    plru_next = {lru_out[2], 1'b1, 1'b1};
            2'd1:    plru_next = {lru_out[2], 1'b0, 1'b1};
            2'd2:    plru_next = {1'b1, lru_out[1], 1'b0};
            default: plru_next = {1'b0, lru_out[1], 1'b0};
        endcase
    end

    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        write_d         = write_q;
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        read_en         = 1'b0;
        tag_load        = '0;
        valid_load      = '0;
        dirty_load      = '0;
        valid_in        = '0;
        dirty_in        = '0;
        write_sel_way   = '0;
        write_read_sel  = '0;
        lru_load        = 1'b0;
        lru_in          = '0;
        way_sel         = 2'd0;
        new_address_sel = 1'b0;
        // Outputs are held low while reset is asserted.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    read_en = 1'b1;
                    if (mem_read || mem_write) begin
                        state_d = CHECK;
                        write_d = mem_write;
                    end
                end
                CHECK: begin
                    read_en = 1'b1;
                    if (hit_any) begin
                        way_sel  = hit_way;
                        mem_resp = 1'b1;
                        lru_load = 1'b1;
                        lru_in   = plru_next;
                        if (write_q) begin
                            write_sel_way[{hit_way, 1'b0} +: 2] = 2'b10;
                            write_read_sel[hit_way] = 1'b1;
                            dirty_load[hit_way]     = 1'b1;
                            dirty_in[hit_way]       = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        way_sel  = plru_victim;
                        victim_d = plru_victim;
                        state_d  = dirty_out[plru_victim] ? WB : ALLOC;
                    end
                end
                WB: begin
                    read_en         = 1'b1;
                    new_address_sel = 1'b1;
                    way_sel         = victim_q;
                    pmem_write      = 1'b1;
                    if (pmem_resp) state_d = ALLOC;
                end
                ALLOC: begin
                    way_sel   = victim_q;
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        write_sel_way[{victim_q, 1'b0} +: 2] = 2'b01;
                        tag_load[victim_q]   = 1'b1;
                        valid_load[victim_q] = 1'b1;
                        valid_in[victim_q]   = 1'b1;
                        dirty_load[victim_q] = 1'b1;
                        state_d = REREAD;
                    end
                end
                REREAD: begin
                    read_en = 1'b1;
                    state_d = CHECK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 2'd0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            write_q  <= write_d;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        reread_q;

    // Hits reached via REREAD complete a miss and are not counted again.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
            reread_q   <= 1'b0;
        end else begin
            reread_q <= (state_q == REREAD);
            if (state_q == CHECK && hit_any && !reread_q && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == CHECK && !hit_any && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == WB && pmem_resp && wb_cnt_q != '1)
                wb_cnt_q <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
    assign wb_count   = 32'd0;
`endif

endmodule

// File: tb/tb_cache_control_4.sv
// Randomized bench for cache_control_4 against a set/way/PLRU cache model.
// The model plays the datapath: it supplies hit/dirty/lru and predicts strobes.
module tb_cache_control_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        pmem_resp = 1'b0;
    logic [3:0]  hit = 4'b0;
    logic [3:0]  dirty_out = 4'b0;
    logic [2:0]  lru_out = 3'b0;
    logic        mem_resp, pmem_read, pmem_write, read_en;
    logic [3:0]  tag_load, valid_load, dirty_load, valid_in, dirty_in;
    logic [7:0]  write_sel_way;
    logic [3:0]  write_read_sel;
    logic        lru_load;
    logic [2:0]  lru_in;
    logic [1:0]  way_sel;
    logic        new_address_sel;
    logic [31:0] hit_count, miss_count, wb_count;

    cache_control_4 dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp),
        .hit(hit), .dirty_out(dirty_out), .lru_out(lru_out),
        .read_en(read_en),
        .tag_load(tag_load), .valid_load(valid_load),
        .dirty_load(dirty_load),
        .valid_in(valid_in), .dirty_in(dirty_in),
        .write_sel_way(write_sel_way), .write_read_sel(write_read_sel),
        .lru_load(lru_load), .lru_in(lru_in), .way_sel(way_sel),
        .new_address_sel(new_address_sel),
        .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         tag_m [8][4];
    bit         val_m [8][4];
    bit         dty_m [8][4];
    logic [2:0] plru_m [8];
    int         hits_m = 0, miss_m = 0, wb_m = 0;
    logic [2:0] last_lru;
    logic [7:0] last_wsel;
    logic [1:0] wb_seen_way;
    bit         wb_seen;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [42:0] all_outs();
        return {mem_resp, pmem_read, pmem_write, read_en, tag_load,
                valid_load, dirty_load, valid_in, dirty_in, write_sel_way,
                write_read_sel, lru_load, lru_in, way_sel, new_address_sel};
    endfunction

    // Tree PLRU: each bit points at the half holding the next victim.
    function automatic int victim_of(logic [2:0] p);
        if (p[0]) return p[2] ? 3 : 2;
        return p[1] ? 1 : 0;
    endfunction

    // Touching a way makes every bit on its path point away from it.
    function automatic logic [2:0] touch(logic [2:0] p, int w);
        logic [2:0] r;
        r = p;
        r[0] = (w < 2);
        if (w < 2) r[1] = (w == 0);
        else       r[2] = (w == 2);
        return r;
    endfunction

    function automatic logic [3:0] dirty_vec(int s);
        logic [3:0] r;
        for (int w = 0; w < 4; w++) r[w] = dty_m[s][w];
        return r;
    endfunction

    task automatic present(int s);
        dirty_out = dirty_vec(s);
        lru_out   = plru_m[s];
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_noload(string tag);
        check(tag, 64'({tag_load, valid_load, dirty_load,
                        write_sel_way, lru_load}), 64'(0));
    endtask

    task automatic check_cnt();
`ifdef CACHE_PERF_CNT_EN
        check("hit_cnt", 64'(hit_count), 64'(hits_m));
        check("miss_cnt", 64'(miss_count), 64'(miss_m));
        check("wb_cnt", 64'(wb_count), 64'(wb_m));
`else
        check("hit_cnt", 64'(hit_count), 64'(0));
        check("miss_cnt", 64'(miss_count), 64'(0));
        check("wb_cnt", 64'(wb_count), 64'(0));
`endif
    endtask

    task automatic do_req(int s, int t, bit wr, int wbw, int alw,
                          bit extra);
        int         hw;
        int         v;
        bit         rr;
        logic [3:0] oh, m;
        logic [7:0] wsel_e;
        logic [2:0] lru_e;
        hw = -1;
        rr = 1'b0;
        for (int w = 0; w < 4; w++)
            if (val_m[s][w] && tag_m[s][w] == t) hw = w;
        mem_write = wr;
        mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        hit = 4'b0;
        present(s);
        #1;
        check("idle_ren", 64'(read_en), 64'(1));
        check("idle_resp", 64'(mem_resp), 64'(0));
        step();
        if (hw < 0) begin
            v = victim_of(plru_m[s]);
            hit = 4'b0;
            present(s);
            #1;
            check("miss_resp", 64'(mem_resp), 64'(0));
            check("miss_way", 64'(way_sel), 64'(v));
            check_noload("miss_ld");
            miss_m++;
            step();
            if (dty_m[s][v]) begin
                for (int i = 0; i <= wbw; i++) begin
                    pmem_resp = (i == wbw);
                    #1;
                    check("wb_ctl", 64'({pmem_write, pmem_read,
                          new_address_sel, read_en, mem_resp}),
                          64'(5'b10110));
                    check("wb_way", 64'(way_sel), 64'(v));
                    wb_seen_way = way_sel;
                    wb_seen = pmem_write;
                    step();
                end
                wb_m++;
            end
            for (int i = 0; i <= alw; i++) begin
                pmem_resp = (i == alw);
                #1;
                check("al_ctl", 64'({pmem_write, pmem_read,
                      new_address_sel, read_en, mem_resp}),
                      64'(5'b01000));
                if (i == alw) begin
                    oh = 4'(1 << v);
                    wsel_e = 8'h01 << (2 * v);
                    check("al_ld", 64'({tag_load, valid_load, valid_in,
                          dirty_load, dirty_in, write_sel_way,
                          write_read_sel}),
                          64'({oh, oh, oh, oh, 4'b0, wsel_e, 4'b0}));
                end else begin
                    check_noload("al_wait");
                end
                step();
            end
            tag_m[s][v] = t;
            val_m[s][v] = 1'b1;
            dty_m[s][v] = 1'b0;
            pmem_resp = 1'b0;
            present(s);
            #1;
            check("reread", 64'({read_en, mem_resp, pmem_read,
                  pmem_write}), 64'(4'b1000));
            step();
            hw = v;
            rr = 1'b1;
        end
        oh = 4'(1 << hw);
        m = (oh << 1) - 4'd1;
        hit = oh | (extra ? (4'($urandom) & ~m) : 4'b0);
        present(s);
        lru_e = touch(plru_m[s], hw);
        wsel_e = 8'h02 << (2 * hw);
        #1;
        check("hit_resp", 64'({mem_resp, lru_load, pmem_read,
              pmem_write}), 64'(4'b1100));
        check("hit_way", 64'(way_sel), 64'(hw));
        check("hit_lru", 64'(lru_in), 64'(lru_e));
        check("hit_wr", 64'({write_sel_way, write_read_sel, dirty_load,
              dirty_in, tag_load, valid_load, valid_in}),
              wr ? 64'({wsel_e, oh, oh, oh, 12'b0}) : 64'(0));
        last_lru  = lru_in;
        last_wsel = write_sel_way;
        plru_m[s] = lru_e;
        if (wr) dty_m[s][hw] = 1'b1;
        if (!rr) hits_m++;
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit       = 4'b0;
        #1;
        check("post_resp", 64'({mem_resp, read_en}), 64'(2'b01));
        check_cnt();
    endtask

    task automatic reset_in_alloc(int s);
        int v;
        v = victim_of(plru_m[s]);
        mem_read = 1'b1;
        present(s);
        step();
        #1;
        check("rst_miss_way", 64'(way_sel), 64'(v));
        step();
        #1;
        check("rst_alloc_pr", 64'(pmem_read), 64'(1));
        rst = 1'b1;
        #1;
        check("rst_outs", 64'(all_outs()), 64'(0));
        step();
        check("rst_pr_drop", 64'({pmem_read, mem_resp}), 64'(0));
        rst = 1'b0;
        mem_read = 1'b0;
        #1;
        check("rst_idle", 64'({read_en, pmem_read, pmem_write, mem_resp}),
              64'(4'b1000));
        hits_m = 0;
        miss_m = 0;
        wb_m = 0;
        step();
        check_cnt();
    endtask

    initial begin
        for (int s = 0; s < 8; s++) begin
            plru_m[s] = 3'b000;
            for (int w = 0; w < 4; w++) begin
                tag_m[s][w] = 0;
                val_m[s][w] = 1'b0;
                dty_m[s][w] = 1'b0;
            end
        end
        wb_seen = 1'b0;
        wb_seen_way = 2'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", 64'(all_outs()), 64'(0));
        check_cnt();
        rst = 1'b0;

        do_req(0, 0, 1'b0, 0, 2, 1'b0);
        check("first_lru", 64'(last_lru), 64'(3'b011));
        do_req(0, 1, 1'b0, 0, 0, 1'b0);
        do_req(0, 2, 1'b0, 0, 1, 1'b0);
        do_req(0, 3, 1'b0, 0, 3, 1'b0);
        do_req(0, 0, 1'b0, 0, 0, 1'b0);
        do_req(0, 1, 1'b1, 0, 0, 1'b0);
        check("wr_way2_sel", 64'(last_wsel), 64'(8'b0010_0000));
        do_req(0, 2, 1'b1, 0, 0, 1'b0);
        do_req(0, 0, 1'b0, 0, 0, 1'b0);
        do_req(0, 3, 1'b0, 0, 0, 1'b0);
        do_req(0, 7, 1'b0, 2, 1, 1'b0);
        check("wb_taken", 64'(wb_seen), 64'(1));
        check("wb_victim1", 64'(wb_seen_way), 64'(1));

        pmem_resp = 1'b1;
        #1;
        check("idle_presp", 64'({pmem_read, pmem_write, mem_resp}),
              64'(0));
        step();
        pmem_resp = 1'b0;
        #1;
        check("idle_stay", 64'({read_en, pmem_read, pmem_write,
              mem_resp}), 64'(4'b1000));
        check_noload("idle_noload");

        reset_in_alloc(5);

        for (int n = 0; n < 300; n++) begin
            do_req($urandom_range(0, 7), $urandom_range(0, 5),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
